// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the simulation console UART.
package sim_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Status word bit positions
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_EMPTY_BIT = 2;
  localparam int unsigned STAT_OCC_LSB   = 8;
  localparam int unsigned STAT_DROP_LSB  = 16;

  // Default register map
  localparam logic [31:0] DEF_TX_ADDR     = 32'h1000_0000;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h1000_0004;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iPush,
  input  logic                       iPop,
  input  logic [WIDTH-1:0]           iData,
  output logic [WIDTH-1:0]           oHead,
  output logic                       oFull,
  output logic                       oEmpty,
  output logic [$clog2(DEPTH):0]     oCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign oFull  = (count_q == FULL_CNT);
  assign oEmpty = (count_q == '0);
  assign oCount = count_q;
  assign oHead  = mem_q[rd_ptr_q];

  assign do_pop  = iPop && !oEmpty;
  assign do_push = iPush && (!oFull || do_pop);

  // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and count registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge iClk) begin
    if (!iRst && do_push) mem_q[wr_ptr_q] <= iData;
  end

endmodule

// File: rtl/sim_uart_tx.sv
// Transmit-only console UART: snoops byte stores to TX_ADDR into a FIFO
// and serialises them as 8N1 frames; exposes a combinational status word.
module sim_uart_tx
  import sim_uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iWriteAddr,
  input  logic [31:0] iWriteData,
  input  logic [3:0]  iWstrb,
  input  logic [31:0] iReadAddr,
  output logic [31:0] oReadData,
  output logic        oReadHit,
  output logic        oTx,
  output logic        oBusy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [7:0]  drop_q, drop_d;

  logic        push_req, pop, drop;
  logic        baud_last;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [CW:0] fifo_count;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{iWriteData[31:8], iWstrb[3:1]};

  assign push_req  = (iWriteAddr == TX_ADDR) && iWstrb[0];
  assign baud_last = (baud_q == BAUD_LAST);
  assign drop      = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (push_req),
    .iPop   (pop),
    .iData  (iWriteData[7:0]),
    .oHead  (fifo_head),
    .oFull  (fifo_full),
    .oEmpty (fifo_empty),
    .oCount (fifo_count)
  );

  // Serialiser next-state; tx_d is the line level for the cycle after the edge
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Saturating count of bytes lost to a full FIFO
  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
  end

  // Serialiser and drop counter registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      drop_q    <= drop_d;
    end
  end

  assign oTx      = tx_q;
  assign oBusy    = (state_q != ST_IDLE) || !fifo_empty;
  assign oReadHit = (iReadAddr == STATUS_ADDR);

  // Status word assembly and read mux
  always_comb begin
    status = '0;
    status[STAT_BUSY_BIT]           = oBusy;
    status[STAT_FULL_BIT]           = fifo_full;
    status[STAT_EMPTY_BIT]          = fifo_empty;
    status[STAT_OCC_LSB +: 8]       = 8'(fifo_count);
    status[STAT_DROP_LSB +: 8]      = drop_q;
    oReadData = oReadHit ? status : '0;
  end

endmodule

// File: tb/tb_sim_uart_tx.sv
// Self-checking bench for sim_uart_tx: queue/timeline reference model,
// per-cycle comparison, directed scenarios and a randomized phase.
module tb_sim_uart_tx;

  localparam logic [31:0] TXA = 32'h1000_0000;
  localparam logic [31:0] STA = 32'h1000_0004;
  localparam int C = 4;
  localparam int D = 8;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iWriteAddr, iWriteData, iReadAddr, oReadData;
  logic [3:0]  iWstrb;
  logic        oReadHit, oTx, oBusy;

  int vectors = 0;
  int miscompares = 0;

  sim_uart_tx #(
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iWriteAddr (iWriteAddr),
    .iWriteData (iWriteData),
    .iWstrb     (iWstrb),
    .iReadAddr  (iReadAddr),
    .oReadData  (oReadData),
    .oReadHit   (oReadHit),
    .oTx        (oTx),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  // Reference model: byte queue plus a frame timeline position
  logic [7:0] mq[$];
  bit         m_valid = 0;
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = '0;
  int         m_drops = 0;

  always @(posedge iClk) begin
    int  pre;
    bit  frame_end, do_pop, push_req;
    if (iRst) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
      m_drops  = 0;
      m_valid  = 1;
    end else begin
      pre       = mq.size();
      frame_end = m_active && (m_pos == 10*C - 1);
      do_pop    = (pre > 0) && (!m_active || frame_end);
      push_req  = (iWriteAddr == TXA) && iWstrb[0];
      if (m_active) begin
        m_pos++;
        if (frame_end) m_active = 0;
      end
      if (do_pop) begin
        m_cur    = mq.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (push_req) begin
        if (pre < D || do_pop) mq.push_back(iWriteData[7:0]);
        else if (m_drops < 255) m_drops++;
      end
    end
  end

  function automatic logic model_tx();
    logic [9:0] fb;
    fb = {1'b1, m_cur, 1'b0};
    return m_active ? fb[m_pos / C] : 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    logic [7:0]  occ, drp;
    occ = 8'(mq.size());
    drp = 8'(m_drops);
    s = {8'h00, drp, occ, 5'b0, (mq.size() == 0), (mq.size() == D),
         (m_active || mq.size() > 0)};
    return (iReadAddr == STA) ? s : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge iClk) begin
    if (m_valid) begin
      chk("tx", {31'b0, oTx}, {31'b0, model_tx()});
      chk("busy", {31'b0, oBusy}, {31'b0, (m_active || mq.size() > 0)});
      chk("hit", {31'b0, oReadHit}, {31'b0, (iReadAddr == STA)});
      chk("status", oReadData, model_status());
    end
  end

  task automatic step(input logic rst, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws);
    iRst = rst; iWriteAddr = wa; iWriteData = wd; iWstrb = ws;
    @(posedge iClk); #2;
    iRst = 1'b0; iWriteAddr = '0; iWriteData = '0; iWstrb = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (oBusy && n < 3000) begin
      idle(1);
      n++;
    end
    chk("drain_done", {31'b0, oBusy}, 32'h0);
  endtask

  logic [9:0]  got_bits;
  logic [9:0]  exp_bits;
  logic [31:0] tmp;

  initial begin
    iRst = 1'b1; iWriteAddr = '0; iWriteData = '0; iWstrb = '0; iReadAddr = STA;

    // Reset, then idle
    step(1'b1, 32'h0, 32'h0, 4'h0);
    step(1'b1, 32'h0, 32'h0, 4'h0);
    idle(100);
    chk("idle_tx", {31'b0, oTx}, 32'h1);
    chk("idle_busy", {31'b0, oBusy}, 32'h0);
    chk("idle_status", oReadData, 32'h0000_0004);

    // Single frame 0x41
    step(1'b0, TXA, 32'hDEAD_BE41, 4'b0001);
    chk("push_tx_still_high", {31'b0, oTx}, 32'h1);
    chk("push_status", oReadData, 32'h0000_0101);
    idle(1);
    chk("start_bit_low", {31'b0, oTx}, 32'h0);
    exp_bits = 10'b10_1000_0010;
    for (int b = 0; b < 10; b++) begin
      got_bits[b] = oTx;
      chk("frame_busy", {31'b0, oBusy}, 32'h1);
      idle(C);
    end
    chk("frame_0x41", {22'b0, got_bits}, {22'b0, exp_bits});
    chk("frame_end_busy", {31'b0, oBusy}, 32'h0);

    // Four back-to-back bytes
    for (int k = 0; k < 4; k++) step(1'b0, TXA, $urandom, 4'b0001);
    chk("occ_after_pop", oReadData, 32'h0000_0301);
    idle(157);
    chk("b2b_busy_tail", {31'b0, oBusy}, 32'h1);
    idle(1);
    chk("b2b_done", {31'b0, oBusy}, 32'h0);

    // Filtered stores
    step(1'b0, 32'h1000_0008, 32'h55, 4'b0001);
    chk("filter_addr", oReadData, 32'h0000_0004);
    step(1'b0, TXA, 32'h66, 4'b0010);
    chk("filter_strb", oReadData, 32'h0000_0004);
    step(1'b0, TXA, 32'h77, 4'b1110);
    chk("filter_strb2", {31'b0, oBusy}, 32'h0);

    // Flood: 12 stores while the line is busy
    for (int k = 0; k < 12; k++) step(1'b0, TXA, $urandom, 4'b1111);
    chk("flood_status", oReadData, 32'h0003_0803);
    idle(29);
    step(1'b0, TXA, 32'hA5, 4'b0001);   // coincides with the pop at frame end
    chk("push_at_pop_full", oReadData, 32'h0003_0803);
    step(1'b0, TXA, 32'hA6, 4'b0001);
    chk("drop_after_pop", oReadData, 32'h0004_0803);
    for (int k = 0; k < 300; k++) step(1'b0, TXA, $urandom, 4'b0001);
    tmp = oReadData;
    chk("drop_saturate", {24'b0, tmp[23:16]}, 32'd255);
    drain();

    // Reset mid-DATA, with a push on the reset edge
    step(1'b0, TXA, 32'hC3, 4'b0001);
    step(1'b0, TXA, 32'h11, 4'b0001);
    step(1'b0, TXA, 32'h22, 4'b0001);
    idle(C + 2*C);
    step(1'b1, TXA, 32'h33, 4'b0001);
    chk("rst_tx", {31'b0, oTx}, 32'h1);
    chk("rst_status", oReadData, 32'h0000_0004);
    for (int k = 0; k < 100; k++) begin
      idle(1);
      if (oTx !== 1'b1 || oBusy !== 1'b0) begin
        chk("post_rst_quiet", {30'b0, oTx, oBusy}, 32'h2);
        break;
      end
    end
    chk("post_rst_status", oReadData, 32'h0000_0004);

    // Randomized phase with alternating store density
    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic [31:0] a;
      logic [3:0]  s;
      int          rate;
      r    = ($urandom_range(0, 999) == 0);
      rate = ((i / 500) % 2 == 0) ? 8 : 60;
      a    = 32'h0;
      s    = 4'h0;
      if ($urandom_range(0, rate - 1) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    a = TXA;
          2:       a = STA;
          default: a = TXA + 32'h8;
        endcase
        s = 4'($urandom_range(0, 15));
      end
      iReadAddr = ($urandom_range(0, 3) != 0) ? STA : $urandom;
      step(r, a, $urandom, s);
    end
    iReadAddr = STA;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
